// File: rtl/stack_pointer.sv
// -----------------------------------------------------------------------------
// stack_pointer
//   32-bit (parameterisable) CPU stack pointer register. Supports hold,
//   increment, decrement and load, selected by a 2-bit drive code. The pointer
//   is registered and driven straight from the flop onto SPOutput, so there is
//   no combinational path from any input to the output.
//
//   Optional feature macro: SP_BOUNDS_CHECK_EN
//     defined   : increments/decrements saturate at SP_LIMIT_HI/SP_LIMIT_LO and
//                 raise a sticky SPFault (cleared by reset or load)
//     undefined : plain modulo-2^WIDTH arithmetic, SPFault tied to 0
//
// Ports
//   clk       in   clock, all state changes on the rising edge
//   rst       in   synchronous active-high reset
//   SPSet     in   [WIDTH] value loaded when SPDrive = 2'b11
//   SPDrive   in   [2]     00 hold, 01 increment, 10 decrement, 11 load
//   SPOutput  out  [WIDTH] current pointer (register output)
//   SPFault   out  sticky bounds-violation flag
// -----------------------------------------------------------------------------
module stack_pointer #(
  parameter int unsigned          WIDTH       = 32,
  parameter logic [WIDTH-1:0]     STEP        = 1,
  parameter logic [WIDTH-1:0]     RESET_VALUE = '0,
  parameter logic [WIDTH-1:0]     SP_LIMIT_LO = '0,
  parameter logic [WIDTH-1:0]     SP_LIMIT_HI = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] SPSet,
  input  logic [1:0]       SPDrive,
  output logic [WIDTH-1:0] SPOutput,
  output logic             SPFault
);

  localparam logic [1:0] DRV_HOLD = 2'b00;
  localparam logic [1:0] DRV_INC  = 2'b01;
  localparam logic [1:0] DRV_DEC  = 2'b10;
  localparam logic [1:0] DRV_LOAD = 2'b11;

  logic [WIDTH-1:0] sp_q, sp_d;

`ifdef SP_BOUNDS_CHECK_EN

  logic             fault_q, fault_d;
  // One extra bit catches wrap past 2^WIDTH-1 (carry) or below 0 (borrow).
  logic [WIDTH:0]   sum_ext, diff_ext;
  logic             below_lo, above_hi;

  assign sum_ext  = {1'b0, sp_q} + {1'b0, STEP};
  assign diff_ext = {1'b0, sp_q} - {1'b0, STEP};
  assign below_lo = (sp_q < SP_LIMIT_LO);
  assign above_hi = (sp_q > SP_LIMIT_HI);

  always_comb begin
    sp_d    = sp_q;
    fault_d = fault_q;
    case (SPDrive)
      DRV_HOLD: begin
        sp_d    = sp_q;
        fault_d = fault_q;
      end
      DRV_INC: begin
        // A pointer already outside the window (only reachable via load) is
        // pulled back to whichever limit it violates.
        if (above_hi) begin
          sp_d    = SP_LIMIT_HI;
          fault_d = 1'b1;
        end else if (below_lo) begin
          sp_d    = SP_LIMIT_LO;
          fault_d = 1'b1;
        end else if (sum_ext[WIDTH] || (sum_ext[WIDTH-1:0] > SP_LIMIT_HI)) begin
          sp_d    = SP_LIMIT_HI;
          fault_d = 1'b1;
        end else begin
          sp_d    = sum_ext[WIDTH-1:0];
        end
      end
      DRV_DEC: begin
        if (above_hi) begin
          sp_d    = SP_LIMIT_HI;
          fault_d = 1'b1;
        end else if (below_lo) begin
          sp_d    = SP_LIMIT_LO;
          fault_d = 1'b1;
        end else if (diff_ext[WIDTH] || (diff_ext[WIDTH-1:0] < SP_LIMIT_LO)) begin
          sp_d    = SP_LIMIT_LO;
          fault_d = 1'b1;
        end else begin
          sp_d    = diff_ext[WIDTH-1:0];
        end
      end
      DRV_LOAD: begin
        sp_d    = SPSet;
        fault_d = 1'b0;
      end
      default: begin
        sp_d    = sp_q;
        fault_d = fault_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q    <= RESET_VALUE;
      fault_q <= 1'b0;
    end else begin
      sp_q    <= sp_d;
      fault_q <= fault_d;
    end
  end

  assign SPFault = fault_q;

`else

  always_comb begin
    sp_d = sp_q;
    case (SPDrive)
      DRV_HOLD: sp_d = sp_q;
      DRV_INC:  sp_d = sp_q + STEP;
      DRV_DEC:  sp_d = sp_q - STEP;
      DRV_LOAD: sp_d = SPSet;
      default:  sp_d = sp_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q <= RESET_VALUE;
    end else begin
      sp_q <= sp_d;
    end
  end

  assign SPFault = 1'b0;

`endif

  assign SPOutput = sp_q;

endmodule

// File: tb/tb_stack_pointer.sv
// -----------------------------------------------------------------------------
// tb_stack_pointer
//   Directed bench for stack_pointer. Inputs change on the falling edge, the
//   DUT is sampled 1 ns after each rising edge. Expected values are written
//   out by hand for each step.
// -----------------------------------------------------------------------------
module tb_stack_pointer;

  logic        clk;
  logic        rst;
  logic [31:0] SPSet;
  logic [1:0]  SPDrive;
  logic [31:0] SPOutput;
  logic        SPFault;

  int n_cmp;
  int n_bad;

`ifdef SP_BOUNDS_CHECK_EN
  // Keep the arithmetic tests inside the 16..32 window.
  localparam logic [31:0] BASE = 32'd20;
`else
  localparam logic [31:0] BASE = 32'd5791;
`endif

  stack_pointer #(
    .WIDTH      (32),
    .STEP       (32'd1),
    .RESET_VALUE(32'd0),
    .SP_LIMIT_LO(32'd16),
    .SP_LIMIT_HI(32'd32)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .SPSet   (SPSet),
    .SPDrive (SPDrive),
    .SPOutput(SPOutput),
    .SPFault (SPFault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one set of inputs across a single rising edge, then sample.
  task automatic step(input logic r, input logic [1:0] drv, input logic [31:0] val);
    @(negedge clk);
    rst     = r;
    SPDrive = drv;
    SPSet   = val;
    @(posedge clk);
    #1;
  endtask

  task automatic check_sp(input string tag, input logic [31:0] exp);
    n_cmp++;
    assert (SPOutput === exp)
      else begin
        n_bad++;
        $error("FAIL %s: SPOutput got %0d (0x%08h) want %0d (0x%08h)", tag, SPOutput, SPOutput, exp, exp);
      end
  endtask

  task automatic check_flt(input string tag, input logic exp);
    n_cmp++;
    assert (SPFault === exp)
      else begin
        n_bad++;
        $error("FAIL %s: SPFault got %b want %b", tag, SPFault, exp);
      end
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    rst     = 1'b1;
    SPDrive = 2'b00;
    SPSet   = 32'd0;

    // Reset then hold
    step(1'b1, 2'b00, 32'd0);
    check_sp ("reset_sp", 32'd0);
    check_flt("reset_flt", 1'b0);
    step(1'b0, 2'b00, 32'd5791);
    check_sp ("hold_after_reset", 32'd0);

    // Load and hold
    step(1'b0, 2'b11, 32'd5791);
    check_sp ("load_5791", 32'd5791);
    check_flt("load_flt", 1'b0);
    step(1'b0, 2'b00, 32'd7894);
    check_sp ("hold_ignores_set", 32'd5791);

    // Increment / decrement around BASE
    step(1'b0, 2'b11, BASE);
    check_sp ("load_base", BASE);
    step(1'b0, 2'b01, 32'd0);
    check_sp ("inc_1", BASE + 32'd1);
    step(1'b0, 2'b01, 32'd0);
    check_sp ("inc_2", BASE + 32'd2);
    step(1'b0, 2'b10, 32'd0);
    check_sp ("dec_1", BASE + 32'd1);
    check_flt("incdec_flt", 1'b0);

`ifdef SP_BOUNDS_CHECK_EN
    // Saturate at the high limit, fault is sticky
    step(1'b0, 2'b11, 32'd32);
    check_sp ("load_hi", 32'd32);
    check_flt("load_hi_flt", 1'b0);
    step(1'b0, 2'b01, 32'd0);
    check_sp ("inc_sat_hi", 32'd32);
    check_flt("inc_sat_hi_flt", 1'b1);
    step(1'b0, 2'b00, 32'd0);
    check_flt("fault_sticky_hold", 1'b1);
    step(1'b0, 2'b10, 32'd0);
    check_sp ("dec_after_fault", 32'd31);
    check_flt("fault_sticky_dec", 1'b1);

    // Load clears fault, saturate at the low limit
    step(1'b0, 2'b11, 32'd16);
    check_sp ("load_lo", 32'd16);
    check_flt("load_clears_flt", 1'b0);
    step(1'b0, 2'b10, 32'd0);
    check_sp ("dec_sat_lo", 32'd16);
    check_flt("dec_sat_lo_flt", 1'b1);

    // Out-of-range loads clamp to the violated limit
    step(1'b0, 2'b11, 32'd40);
    check_sp ("load_above", 32'd40);
    check_flt("load_above_flt", 1'b0);
    step(1'b0, 2'b10, 32'd0);
    check_sp ("dec_from_above", 32'd32);
    check_flt("dec_from_above_flt", 1'b1);
    step(1'b0, 2'b11, 32'd5);
    step(1'b0, 2'b01, 32'd0);
    check_sp ("inc_from_below", 32'd16);
    check_flt("inc_from_below_flt", 1'b1);

    // Wrap past the top of the address space is also a saturation
    step(1'b0, 2'b11, 32'hFFFF_FFFF);
    step(1'b0, 2'b01, 32'd0);
    check_sp ("inc_from_max", 32'd32);
    check_flt("inc_from_max_flt", 1'b1);
`else
    // Modulo wrap, no fault
    step(1'b0, 2'b11, 32'hFFFF_FFFF);
    check_sp ("load_max", 32'hFFFF_FFFF);
    step(1'b0, 2'b01, 32'd0);
    check_sp ("inc_wrap", 32'd0);
    check_flt("inc_wrap_flt", 1'b0);
    step(1'b0, 2'b10, 32'd0);
    check_sp ("dec_wrap", 32'hFFFF_FFFF);
    check_flt("dec_wrap_flt", 1'b0);
`endif

    // Reset wins over a pending increment
    step(1'b0, 2'b11, BASE);
    check_sp ("load_before_rst", BASE);
    step(1'b1, 2'b01, 32'd0);
    check_sp ("rst_over_inc", 32'd0);
    check_flt("rst_over_inc_flt", 1'b0);
    step(1'b0, 2'b00, 32'd0);
    check_sp ("hold_after_rst", 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
